// File: rtl/hbm_strided_read_if.sv
// hbm_strided_read_if
//   AXI4 read channel (AR + R) of one HBM pseudo-channel together with the
//   downstream beat stream (dn_*) that carries returned data into the engine.
//   master : the strided read engine (drives AR, RREADY, dn_vld/dn_dat/dn_last)
//   slave  : the memory side and the downstream consumer
interface hbm_strided_read_if #(
  parameter int ADDR_WIDTH = 33,
  parameter int DATA_WIDTH = 256,
  parameter int ID_WIDTH   = 5
);
  logic                  m_axi_ARVALID;
  logic                  m_axi_ARREADY;
  logic [ADDR_WIDTH-1:0] m_axi_ARADDR;
  logic [ID_WIDTH-1:0]   m_axi_ARID;
  logic [7:0]            m_axi_ARLEN;
  logic [2:0]            m_axi_ARSIZE;
  logic [1:0]            m_axi_ARBURST;
  logic [1:0]            m_axi_ARLOCK;
  logic [3:0]            m_axi_ARCACHE;
  logic [2:0]            m_axi_ARPROT;
  logic [3:0]            m_axi_ARQOS;
  logic [3:0]            m_axi_ARREGION;

  logic                  m_axi_RVALID;
  logic [DATA_WIDTH-1:0] m_axi_RDATA;
  logic [1:0]            m_axi_RRESP;
  logic                  m_axi_RLAST;
  logic [ID_WIDTH-1:0]   m_axi_RID;
  logic                  m_axi_RREADY;

  logic                  dn_vld;
  logic [DATA_WIDTH-1:0] dn_dat;
  logic                  dn_last;
  logic                  dn_rdy;

  modport master (
    output m_axi_ARVALID, m_axi_ARADDR, m_axi_ARID, m_axi_ARLEN, m_axi_ARSIZE,
           m_axi_ARBURST, m_axi_ARLOCK, m_axi_ARCACHE, m_axi_ARPROT, m_axi_ARQOS,
           m_axi_ARREGION, m_axi_RREADY, dn_vld, dn_dat, dn_last,
    input  m_axi_ARREADY, m_axi_RVALID, m_axi_RDATA, m_axi_RRESP, m_axi_RLAST,
           m_axi_RID, dn_rdy
  );

  modport slave (
    input  m_axi_ARVALID, m_axi_ARADDR, m_axi_ARID, m_axi_ARLEN, m_axi_ARSIZE,
           m_axi_ARBURST, m_axi_ARLOCK, m_axi_ARCACHE, m_axi_ARPROT, m_axi_ARQOS,
           m_axi_ARREGION, m_axi_RREADY, dn_vld, dn_dat, dn_last,
    output m_axi_ARREADY, m_axi_RVALID, m_axi_RDATA, m_axi_RRESP, m_axi_RLAST,
           m_axi_RID, dn_rdy
  );
endinterface

// File: rtl/hbm_strided_read.sv
// hbm_strided_read
//   Strided AXI4 read master for one HBM pseudo-channel. On start_read it
//   issues read_ops fixed-length INCR bursts at base + k*stride, keeps at most
//   MAX_OUTSTANDING bursts in flight and passes returned beats straight
//   through to the downstream datapath.
// Ports
//   clk, rst        clock, synchronous active-high reset
//   start_read      one-cycle start pulse, honoured only when idle
//   read_ops        number of bursts
//   stride          byte distance between consecutive burst addresses
//   init_addr       base address, bits [27:0] used
//   mem_burst_size  bytes per burst
//   busy/done/err   status: in progress, end-of-transfer pulse, sticky error
//   axi             AXI read channel plus downstream stream (master modport)
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | waiting for start_read
// S_ADDR  | issuing AR bursts (data may already be returning)
// S_DRAIN | all ARs issued, waiting for the final data beat
module hbm_strided_read #(
  parameter int ENGINE_ID       = 0,
  parameter int ADDR_WIDTH      = 33,
  parameter int DATA_WIDTH      = 256,
  parameter int ID_WIDTH        = 5,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_read,
  input  logic [31:0]           read_ops,
  input  logic [31:0]           stride,
  input  logic [ADDR_WIDTH-1:0] init_addr,
  input  logic [15:0]           mem_burst_size,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  hbm_strided_read_if.master    axi
);

  localparam int              BEAT_SHIFT = (DATA_WIDTH == 512) ? 6 : 5;
  localparam logic [2:0]      SIZE_CODE  = (DATA_WIDTH == 512) ? 3'b110 : 3'b101;
  localparam logic [3:0]      ENG_BITS   = 4'(ENGINE_ID);
  localparam int              OW         = $clog2(MAX_OUTSTANDING) + 1;
  localparam logic [OW-1:0]   OUT_MAX    = OW'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DRAIN} state_t;

  state_t                state, state_nxt;
  logic [31:0]           ops_q;
  logic [31:0]           stride_q;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [ADDR_WIDTH-1:0] offset_q;
  logic [7:0]            arlen_q;
  logic [2:0]            arsize_q;
  logic [31:0]           ar_cnt;
  logic [31:0]           burst_cnt;
  logic [7:0]            beat_cnt;
  logic [OW-1:0]         outstanding;
  logic                  err_q;
  logic                  done_q;

  logic                  ar_valid;
  logic                  ar_hs;
  logic                  r_hs;
  logic                  beat_last;
  logic                  burst_last;
  logic                  final_beat;
  logic                  start_acc;
  logic [ADDR_WIDTH-1:0] base_d;
  logic [15:0]           beats_d;
  logic                  unused_ok;

  assign busy       = (state != S_IDLE);
  assign start_acc  = start_read & (state == S_IDLE);
  assign ar_hs      = ar_valid & axi.m_axi_ARREADY;
  assign r_hs       = axi.m_axi_RVALID & axi.m_axi_RREADY;
  assign beat_last  = (beat_cnt == arlen_q);
  assign burst_last = (burst_cnt == ops_q - 32'd1);
  assign final_beat = r_hs & beat_last & burst_last;
  assign beats_d    = mem_burst_size >> BEAT_SHIFT;
  assign unused_ok  = ^{init_addr[ADDR_WIDTH-1:28], axi.m_axi_RID};

  // Engine index sits in [31:28] so each engine reads its own HBM window.
  always_comb begin
    base_d         = '0;
    base_d[27:0]   = init_addr[27:0];
    base_d[31:28]  = ENG_BITS;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ar_valid  = 1'b0;
    case (state)
      S_IDLE: begin
        if (start_read && read_ops != 32'd0) state_nxt = S_ADDR;
      end
      S_ADDR: begin
        // Outstanding only drops while waiting, so ARVALID cannot fall
        // before its handshake once raised.
        ar_valid = (outstanding < OUT_MAX);
        if (ar_valid && axi.m_axi_ARREADY && ar_cnt == ops_q - 32'd1)
          state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (final_beat) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ops_q       <= '0;
      stride_q    <= '0;
      base_q      <= '0;
      offset_q    <= '0;
      arlen_q     <= '0;
      arsize_q    <= '0;
      ar_cnt      <= '0;
      burst_cnt   <= '0;
      beat_cnt    <= '0;
      outstanding <= '0;
      err_q       <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start_acc) begin
        ops_q       <= read_ops;
        stride_q    <= stride;
        base_q      <= base_d;
        arlen_q     <= 8'(beats_d - 16'd1);
        arsize_q    <= SIZE_CODE;
        offset_q    <= '0;
        ar_cnt      <= '0;
        burst_cnt   <= '0;
        beat_cnt    <= '0;
        outstanding <= '0;
        err_q       <= 1'b0;
        done_q      <= (read_ops == 32'd0);
      end else begin
        if (ar_hs) begin
          offset_q <= offset_q + ADDR_WIDTH'(stride_q);
          ar_cnt   <= ar_cnt + 32'd1;
        end
        // A misbehaving slave can send extra RLASTs; never wrap below zero.
        case ({ar_hs, r_hs & axi.m_axi_RLAST})
          2'b10:   outstanding <= outstanding + OW'(1);
          2'b01:   if (outstanding != '0) outstanding <= outstanding - OW'(1);
          default: outstanding <= outstanding;
        endcase
        if (r_hs) begin
          if (beat_last) begin
            beat_cnt  <= '0;
            burst_cnt <= burst_cnt + 32'd1;
          end else begin
            beat_cnt  <= beat_cnt + 8'd1;
          end
          // Completion tracks local counters; RLAST is only cross-checked.
          if (axi.m_axi_RRESP != 2'b00 || axi.m_axi_RLAST != beat_last)
            err_q <= 1'b1;
          if (final_beat && state == S_DRAIN)
            done_q <= 1'b1;
        end
      end
    end
  end

  assign done = done_q;
  assign err  = err_q;

  assign axi.m_axi_ARVALID  = ar_valid;
  assign axi.m_axi_ARADDR   = base_q + offset_q;
  assign axi.m_axi_ARID     = '0;
  assign axi.m_axi_ARLEN    = arlen_q;
  assign axi.m_axi_ARSIZE   = arsize_q;
  assign axi.m_axi_ARBURST  = 2'b01;
  assign axi.m_axi_ARLOCK   = 2'b00;
  assign axi.m_axi_ARCACHE  = 4'b0000;
  assign axi.m_axi_ARPROT   = 3'b010;
  assign axi.m_axi_ARQOS    = 4'b0000;
  assign axi.m_axi_ARREGION = 4'b0000;

  assign axi.m_axi_RREADY = axi.dn_rdy & busy;
  assign axi.dn_vld       = axi.m_axi_RVALID & busy;
  assign axi.dn_dat       = axi.m_axi_RDATA;
  assign axi.dn_last      = axi.m_axi_RVALID & busy & burst_last & beat_last;

endmodule
